// File: rtl/cpu_defs_pkg.sv
// Shared CPU-wide widths and the write-request record exchanged between WB, the LLU and the regfile.
package cpu_defs_pkg;
    localparam int REG_AW   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 1 << REG_AW;

    typedef struct packed {
        logic [REG_AW-1:0] wa;
        logic [DATA_W-1:0] wd;
    } wb_req_t;
endpackage

// File: rtl/rf_wb_fifo.sv
// Small synchronous FIFO buffering LLU results until the regfile write port is free.
module rf_wb_fifo
    import cpu_defs_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    i_push,
    input  wb_req_t i_data,
    input  logic    i_pop,
    output logic    o_full,
    output logic    o_empty,
    output wb_req_t o_head
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    wb_req_t        r_mem [DEPTH];
    logic [PW-1:0]  r_rd_ptr;
    logic [PW-1:0]  r_wr_ptr;
    logic [PW:0]    r_cnt;
    logic           w_push;
    logic           w_pop;

    assign o_full  = (r_cnt == FULL_CNT);
    assign o_empty = (r_cnt == '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Regfile write-port arbiter: WB pipe has priority, buffered LLU results fill idle slots,
// a scoreboard tracks outstanding LLU destinations and a starvation counter requests WB stalls.
module rf_wb_arbiter
    import cpu_defs_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallW,
    input  logic              pipe_we,
    input  logic [REG_AW-1:0] pipe_wa,
    input  logic [DATA_W-1:0] pipe_wd,
    input  logic              llu_issue_valid,
    input  logic [REG_AW-1:0] llu_issue_wa,
    output logic              llu_issue_ready,
    input  logic              llu_req,
    input  logic [REG_AW-1:0] llu_wa,
    input  logic [DATA_W-1:0] llu_wd,
    output logic              llu_ready,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_wa,
    output logic [DATA_W-1:0] rf_wd,
    input  logic [REG_AW-1:0] q_ra1,
    input  logic [REG_AW-1:0] q_ra2,
    output logic              q_busy1,
    output logic              q_busy2,
    output logic              wb_hold,
    output logic [NUM_REGS-1:0] busy_vec
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    logic [NUM_REGS-1:0] r_busy;
    logic [SW-1:0]       r_starve;
    logic                w_full;
    logic                w_empty;
    wb_req_t             w_head;
    wb_req_t             w_push_data;
    logic                w_pipe_wr;
    logic                w_grant;
    logic                w_issue_acc;
    logic [NUM_REGS-1:0] w_set;
    logic [NUM_REGS-1:0] w_clr;

    assign w_push_data = '{wa: llu_wa, wd: llu_wd};

    rf_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (llu_req & llu_ready),
        .i_data  (w_push_data),
        .i_pop   (w_grant),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    // Outputs are forced to their idle values while reset is held.
    assign w_pipe_wr = ~rst & pipe_we & ~stallW & (pipe_wa != '0);
    assign w_grant   = ~rst & ~w_empty & ~w_pipe_wr;

    assign rf_we = w_pipe_wr | (w_grant & (w_head.wa != '0));
    assign rf_wa = w_pipe_wr ? pipe_wa : w_head.wa;
    assign rf_wd = w_pipe_wr ? pipe_wd : w_head.wd;

    assign llu_ready       = rst | ~w_full;
    assign llu_issue_ready = rst | ~r_busy[llu_issue_wa];
    assign w_issue_acc     = ~rst & llu_issue_valid & ~r_busy[llu_issue_wa];

    assign w_set = w_issue_acc ? (NUM_REGS'(1) << llu_issue_wa) : '0;
    assign w_clr = w_grant     ? (NUM_REGS'(1) << w_head.wa)    : '0;

    always_ff @(posedge clk) begin
        if (rst)
            r_busy <= '0;
        else
            r_busy <= ((r_busy & ~w_clr) | w_set) & ~NUM_REGS'(1);
    end

    always_ff @(posedge clk) begin
        if (rst || w_empty || w_grant)
            r_starve <= '0;
        else if (r_starve != SMAX)
            r_starve <= r_starve + 1'b1;
    end

    assign wb_hold  = ~rst & (r_starve == SMAX);
    assign q_busy1  = ~rst & r_busy[q_ra1];
    assign q_busy2  = ~rst & r_busy[q_ra2];
    assign busy_vec = r_busy;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter (FIFO_DEPTH=2, STARVE_MAX=4).
module tb_rf_wb_arbiter;
    logic        clk = 0;
    logic        rst = 1;
    logic        stallW = 0;
    logic        pipe_we = 0;
    logic [4:0]  pipe_wa = 0;
    logic [31:0] pipe_wd = 0;
    logic        llu_issue_valid = 0;
    logic [4:0]  llu_issue_wa = 0;
    logic        llu_issue_ready;
    logic        llu_req = 0;
    logic [4:0]  llu_wa = 0;
    logic [31:0] llu_wd = 0;
    logic        llu_ready;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [4:0]  q_ra1 = 8;
    logic [4:0]  q_ra2 = 20;
    logic        q_busy1, q_busy2, wb_hold;
    logic [31:0] busy_vec;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.FIFO_DEPTH(2), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst), .stallW(stallW),
        .pipe_we(pipe_we), .pipe_wa(pipe_wa), .pipe_wd(pipe_wd),
        .llu_issue_valid(llu_issue_valid), .llu_issue_wa(llu_issue_wa),
        .llu_issue_ready(llu_issue_ready),
        .llu_req(llu_req), .llu_wa(llu_wa), .llu_wd(llu_wd), .llu_ready(llu_ready),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .q_ra1(q_ra1), .q_ra2(q_ra2), .q_busy1(q_busy1), .q_busy2(q_busy2),
        .wb_hold(wb_hold), .busy_vec(busy_vec)
    );

    // Inputs change at negedge; outputs are sampled 1ns later, well before posedge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        step(); step();
        pipe_we = 1; pipe_wa = 5; pipe_wd = 32'h1111_0000;
        #1;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we: got %0b want 0", rf_we); end
        checks++; if (llu_ready !== 1'b1) begin errors++; $display("FAIL reset_llu_ready: got %0b want 1", llu_ready); end
        checks++; if (llu_issue_ready !== 1'b1) begin errors++; $display("FAIL reset_issue_ready: got %0b want 1", llu_issue_ready); end
        checks++; if (wb_hold !== 1'b0) begin errors++; $display("FAIL reset_wb_hold: got %0b want 0", wb_hold); end
        checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL reset_busy: got %h want 0", busy_vec); end
        checks++; if (q_busy1 !== 1'b0 || q_busy2 !== 1'b0) begin errors++; $display("FAIL reset_q_busy: got %0b%0b want 00", q_busy1, q_busy2); end
        step();
        rst = 0; pipe_we = 0;
    endtask

    task automatic test_pipe();
        pipe_we = 1; pipe_wa = 5; pipe_wd = 32'hA5A5_0001; stallW = 0;
        #1;
        checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd5 || rf_wd !== 32'hA5A5_0001) begin
            errors++; $display("FAIL pipe_write: got we=%0b wa=%0d wd=%h want 1/5/a5a50001", rf_we, rf_wa, rf_wd); end
        stallW = 1;
        #1;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL pipe_stalled: got %0b want 0", rf_we); end
        stallW = 0; pipe_wa = 0;
        #1;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL pipe_wa0: got %0b want 0", rf_we); end
        step();
        pipe_we = 0;
    endtask

    task automatic test_llu_basic();
        llu_issue_valid = 1; llu_issue_wa = 8;
        #1;
        checks++; if (llu_issue_ready !== 1'b1 || q_busy1 !== 1'b0) begin
            errors++; $display("FAIL issue8: got ready=%0b qb=%0b want 1/0", llu_issue_ready, q_busy1); end
        step();
        llu_issue_valid = 0;
        #1;
        checks++; if (q_busy1 !== 1'b1 || busy_vec !== 32'h0000_0100) begin
            errors++; $display("FAIL busy8_set: got qb=%0b vec=%h want 1/00000100", q_busy1, busy_vec); end
        step();
        llu_req = 1; llu_wa = 8; llu_wd = 32'h1234;
        #1;
        checks++; if (llu_ready !== 1'b1 || rf_we !== 1'b0) begin
            errors++; $display("FAIL llu_push: got ready=%0b we=%0b want 1/0", llu_ready, rf_we); end
        step();
        llu_req = 0;
        #1;
        checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd8 || rf_wd !== 32'h1234 || busy_vec !== 32'h0000_0100) begin
            errors++; $display("FAIL llu_write: got we=%0b wa=%0d wd=%h vec=%h want 1/8/1234/00000100", rf_we, rf_wa, rf_wd, busy_vec); end
        step();
        #1;
        checks++; if (busy_vec !== 32'h0 || q_busy1 !== 1'b0 || rf_we !== 1'b0) begin
            errors++; $display("FAIL busy8_clr: got vec=%h qb=%0b we=%0b want 0/0/0", busy_vec, q_busy1, rf_we); end
    endtask

    task automatic test_starve();
        pipe_we = 1; pipe_wa = 3; pipe_wd = 32'h3333;
        llu_req = 1; llu_wa = 9; llu_wd = 32'h99;
        step();
        llu_req = 0;
        for (int k = 1; k <= 5; k++) begin
            #1;
            checks++; if (wb_hold !== (k == 5) || rf_wa !== 5'd3) begin
                errors++; $display("FAIL starve_cycle%0d: got hold=%0b wa=%0d want %0b/3", k, wb_hold, rf_wa, (k == 5)); end
            if (k < 5) step();
        end
        stallW = 1;
        #1;
        checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd9 || rf_wd !== 32'h99) begin
            errors++; $display("FAIL starve_drain: got we=%0b wa=%0d wd=%h want 1/9/99", rf_we, rf_wa, rf_wd); end
        step();
        stallW = 0;
        #1;
        checks++; if (wb_hold !== 1'b0 || rf_wa !== 5'd3) begin
            errors++; $display("FAIL starve_release: got hold=%0b wa=%0d want 0/3", wb_hold, rf_wa); end
        step();
        pipe_we = 0;
    endtask

    task automatic test_back_to_back();
        pipe_we = 1; pipe_wa = 3;
        llu_req = 1; llu_wa = 10; llu_wd = 32'hA;
        #1;
        checks++; if (llu_ready !== 1'b1) begin errors++; $display("FAIL fill0_ready: got %0b want 1", llu_ready); end
        step();
        llu_wa = 11; llu_wd = 32'hB;
        #1;
        checks++; if (llu_ready !== 1'b1) begin errors++; $display("FAIL fill1_ready: got %0b want 1", llu_ready); end
        step();
        llu_wa = 12; llu_wd = 32'hC;
        #1;
        checks++; if (llu_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %0b want 0", llu_ready); end
        step();
        pipe_we = 0;
        #1;
        checks++; if (llu_ready !== 1'b0 || rf_we !== 1'b1 || rf_wa !== 5'd10 || rf_wd !== 32'hA) begin
            errors++; $display("FAIL pop10: got ready=%0b we=%0b wa=%0d wd=%h want 0/1/10/a", llu_ready, rf_we, rf_wa, rf_wd); end
        step();
        #1;
        checks++; if (llu_ready !== 1'b1 || rf_wa !== 5'd11 || rf_wd !== 32'hB) begin
            errors++; $display("FAIL pop11: got ready=%0b wa=%0d wd=%h want 1/11/b", llu_ready, rf_wa, rf_wd); end
        step();
        llu_req = 0;
        #1;
        checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd12 || rf_wd !== 32'hC) begin
            errors++; $display("FAIL pop12: got we=%0b wa=%0d wd=%h want 1/12/c", rf_we, rf_wa, rf_wd); end
        step();
        #1;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL drained: got %0b want 0", rf_we); end
    endtask

    task automatic test_reject();
        llu_issue_valid = 1; llu_issue_wa = 8;
        step();
        #1;
        checks++; if (llu_issue_ready !== 1'b0) begin errors++; $display("FAIL issue_busy: got %0b want 0", llu_issue_ready); end
        llu_issue_wa = 0;
        #1;
        checks++; if (llu_issue_ready !== 1'b1) begin errors++; $display("FAIL issue_wa0: got %0b want 1", llu_issue_ready); end
        step();
        llu_issue_valid = 0;
        llu_req = 1; llu_wa = 0; llu_wd = 32'hDEAD;
        #1;
        checks++; if (busy_vec !== 32'h0000_0100) begin errors++; $display("FAIL busy_after_wa0: got %h want 00000100", busy_vec); end
        step();
        llu_req = 0;
        #1;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL wa0_pop: got %0b want 0", rf_we); end
    endtask

    task automatic test_reset_midflight();
        pipe_we = 1; pipe_wa = 3;
        llu_req = 1; llu_wa = 13; llu_wd = 32'hD;
        step();
        llu_wa = 14; llu_wd = 32'hE;
        step();
        llu_req = 0;
        #1;
        checks++; if (llu_ready !== 1'b0 || busy_vec !== 32'h0000_0100) begin
            errors++; $display("FAIL pre_rst: got ready=%0b vec=%h want 0/00000100", llu_ready, busy_vec); end
        rst = 1; pipe_we = 0;
        #1;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL in_rst_we: got %0b want 0", rf_we); end
        step();
        rst = 0;
        #1;
        checks++; if (busy_vec !== 32'h0 || llu_ready !== 1'b1 || rf_we !== 1'b0 || wb_hold !== 1'b0) begin
            errors++; $display("FAIL post_rst: got vec=%h ready=%0b we=%0b hold=%0b want 0/1/0/0", busy_vec, llu_ready, rf_we, wb_hold); end
    endtask

    task automatic test_issue_and_grant();
        llu_issue_valid = 1; llu_issue_wa = 21;
        step();
        llu_issue_valid = 0;
        llu_req = 1; llu_wa = 21; llu_wd = 32'h21;
        step();
        llu_req = 0;
        llu_issue_valid = 1; llu_issue_wa = 20;
        #1;
        checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd21 || llu_issue_ready !== 1'b1) begin
            errors++; $display("FAIL issue_grant: got we=%0b wa=%0d ready=%0b want 1/21/1", rf_we, rf_wa, llu_issue_ready); end
        step();
        llu_issue_valid = 0;
        #1;
        checks++; if (busy_vec !== 32'h0010_0000 || q_busy2 !== 1'b1) begin
            errors++; $display("FAIL issue_grant_vec: got vec=%h qb2=%0b want 00100000/1", busy_vec, q_busy2); end
    endtask

    initial begin
        test_reset();
        test_pipe();
        test_llu_basic();
        test_starve();
        test_back_to_back();
        test_reject();
        test_reset_midflight();
        test_issue_and_grant();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-port arbiter and scoreboard for the 32×32 register file. It shares the single regfile write port between the in-order WB stage and one long-latency unit (LLU: divider / late load return). It tracks which registers have an LLU result outstanding so the hazard unit can stall readers. It sits between WB, the LLU and the regfile write port; the regfile instance ties its own `stallW` to 0, because this block already applies stall gating.

## Interface
- `FIFO_DEPTH`, 2: LLU result buffer entries; power of two, ≥2.
- `STARVE_MAX`, 4: cycles a buffered LLU result may wait before `wb_hold` asserts; 1..15.

- `clk`  in  1  clock, all state updates on posedge
- `rst`  in  1  synchronous, active-high reset
- `stallW`  in  1  WB stage stalled; a pipe write is suppressed this cycle
- `pipe_we`, `pipe_wa`, `pipe_wd`  in  1/5/32  WB-stage write request
- `llu_issue_valid`, `llu_issue_wa`  in  1/5  LLU accepted an op targeting `llu_issue_wa`
- `llu_issue_ready`  out  1  issue accepted; low when `busy[llu_issue_wa]`
- `llu_req`, `llu_wa`, `llu_wd`  in  1/5/32  LLU result; held stable until `llu_ready`
- `llu_ready`  out  1  buffer not full
- `rf_we`, `rf_wa`, `rf_wd`  out  1/5/32  regfile write port
- `q_ra1`, `q_ra2`  in  5  read-address query from decode
- `q_busy1`, `q_busy2`  out  1  queried register has an LLU result outstanding
- `wb_hold`  out  1  request to the hazard unit to stall WB next cycle
- `busy_vec`  out  32  scoreboard contents (debug)

## Operation
- Pipe path is combinational and has priority. If `pipe_we & ~stallW & pipe_wa!=0`, the pipe write drives `rf_*`.
- LLU path:
  - Push into the FIFO on `llu_req & llu_ready`.
  - Grant the FIFO head when the buffer is non-empty and the pipe path is not writing. This includes every cycle where `stallW=1`, `pipe_we=0` or `pipe_wa=0`.
  - On grant: pop the head. Drive `rf_*` from the head when `head.wa!=0`. A head with `wa=0` pops without asserting `rf_we`.
- Scoreboard `busy[31:0]`:
  - Set on `llu_issue_valid & llu_issue_ready & llu_issue_wa!=0`.
  - Cleared for `head.wa` on grant.
  - `busy[0]` is always 0.
  - Issue to a busy register is rejected (`llu_issue_ready=0`), even if that register clears in the same cycle.
- `q_busyN = busy[q_raN]`, combinational.
- Starvation counter `starve`, width ceil(log2(STARVE_MAX+1)):
  - Increments each cycle the FIFO is non-empty and not granted.
  - Clears on grant or when the FIFO is empty.
  - Saturates at STARVE_MAX.
  - `wb_hold = (starve==STARVE_MAX)`, combinational.
- Precondition, enforced by the hazard unit: no pipe write targets a busy register (WAW). This block does not check it.

## Timing
- Reset:
  - FIFO empty, `busy_vec=0`, `starve=0`.
  - Outputs during reset: `rf_we=0`, `llu_ready=1`, `llu_issue_ready=1`, `wb_hold=0`, `q_busy*=0`.
- Pipe write: 0-cycle latency from inputs to `rf_*`.
- LLU result pushed at cycle t becomes head at t+1. Its earliest `rf_we` is at t+1, and `busy` clears at the end of the granted cycle.
- Full buffer:
  - `llu_ready=0`.
  - A push and a pop in the same cycle do not both happen when full, because ready is computed from the current count. The push is deferred.
- Empty buffer: no LLU grant. `starve` holds at 0.
- Issue and grant in the same cycle for different registers: both take effect.
- Issue to a register with `wa=0`: `llu_issue_ready=1`, no busy bit set.
- Pointers wrap modulo FIFO_DEPTH. Count is held in log2(FIFO_DEPTH)+1 bits.

## Structure
- Shared package `cpu_defs_pkg`:
  - `REG_AW=5`, `DATA_W=32`.
  - Typedef `wb_req_t {wa, wd}` shared with the LLU.
- One sub-module `rf_wb_fifo`: a synchronous FIFO with parameter DEPTH, push/pop, full/empty, head output.
- Top level contains the scoreboard, arbiter mux and starvation counter.

## Test plan
- After reset, apply pipe write `wa=5, wd=0xA5A5_0001` with `stallW=0` → `rf_we=1, rf_wa=5` in the same cycle. Repeat with `stallW=1` → `rf_we=0`.
- Issue `wa=8`, then a later LLU result `wa=8, wd=0x1234` pushed while `pipe_we=0`:
  - `q_busy1` (q_ra1=8) is 1 from the cycle after issue.
  - `rf_we` with `wd=0x1234` one cycle after push.
  - `busy_vec[8]=0` the cycle after that write.
- Hold `pipe_we=1, wa=3` every cycle with 1 LLU result buffered, STARVE_MAX=4:
  - `wb_hold=1` on the 5th cycle of waiting.
  - Then raise `stallW` → the LLU result is written that cycle and `wb_hold` drops next cycle.
- Fill the FIFO with 2 results under continuous pipe writes → `llu_ready=0`. The third `llu_req` is held until a pop, then accepted. Results retire in FIFO order.
- Issue to `wa=8` while `busy[8]=1` → `llu_issue_ready=0`. Issue to `wa=0` → ready=1 and `busy_vec` unchanged. An LLU result with `wa=0` pops with `rf_we=0`.
- Assert `rst` with 2 results buffered and `busy[8]=1` → next cycle `busy_vec=0`, FIFO empty, `llu_ready=1`, `rf_we=0`.
